axis_fringe_counter: RTL and testbench

Consumes the same two-channel quadrature sample stream that feeds the extremum finder, together with that finder's `lower_threshold`/`upper_threshold`. It binarises both channels with a hysteresis (Schmitt) comparator, decodes the quadrature sequence into a signed fringe position, and emits the running position as an AXI4-Stream master with backpressure. It sits downstream of the extremum finder, on the receive end of its threshold interface, and feeds the position/velocity path.

---
 rtl/fringe_pkg.sv | 40 ++++
 rtl/hysteresis_comparator.sv | 44 ++++
 rtl/axis_fringe_counter.sv | 113 +++++++++++
 tb/tb_axis_fringe_counter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fringe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fringe_pkg: quadrature state codes, step encoding and decode helper   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package fringe_pkg;

  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q01 = 2'b01;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q10 = 2'b10;

  localparam int ERR_WIDTH = 16;

  typedef enum logic [1:0] {
    DELTA_NONE    = 2'd0,
    DELTA_INC     = 2'd1,
    DELTA_DEC     = 2'd2,
    DELTA_ILLEGAL = 2'd3
  } delta_e;

  function automatic logic [1:0] fwd_next(input logic [1:0] q);
    case (q)
      Q00:     return Q01;
      Q01:     return Q11;
      Q11:     return Q10;
      default: return Q00;
    endcase
  endfunction

  // Any change of both bits at once has no defined direction.
  function automatic delta_e quad_delta(input logic [1:0] prev, input logic [1:0] curr);
    if (prev == curr)             return DELTA_NONE;
    if ((prev ^ curr) == 2'b11)   return DELTA_ILLEGAL;
    if (fwd_next(prev) == curr)   return DELTA_INC;
    return DELTA_DEC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hysteresis_comparator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hysteresis_comparator: Schmitt binariser for one signed channel       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module hysteresis_comparator #(
  parameter int WIDTH = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic signed [WIDTH-1:0] sample,
  input  logic signed [WIDTH-1:0] lower,
  input  logic signed [WIDTH-1:0] upper,
  input  logic                    enable,
  output logic                    bit_next,
  output logic                    bit_q
);

  logic bit_d;

  // Set is tested first so inverted thresholds still resolve deterministically.
  always_comb begin
    bit_d = bit_q;
    if (enable) begin
      if (sample > upper) begin
        bit_d = 1'b1;
      end else if (sample < lower) begin
        bit_d = 1'b0;
      end
    end
  end

  assign bit_next = bit_d;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bit_q <= 1'b0;
    end else begin
      bit_q <= bit_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_fringe_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_fringe_counter: hysteresis + quadrature decode -> AXIS position  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module axis_fringe_counter
  import fringe_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int COUNT_WIDTH      = 32
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic signed [AXIS_TDATA_WIDTH/2-1:0] lower_threshold,
  input  logic signed [AXIS_TDATA_WIDTH/2-1:0] upper_threshold,
  input  logic                                 clear,
  output logic [ERR_WIDTH-1:0]                 error_count,
  input  logic                                 S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0]          S_AXIS_tdata,
  output logic                                 S_AXIS_tready,
  output logic                                 M_AXIS_tvalid,
  output logic [COUNT_WIDTH-1:0]               M_AXIS_tdata,
  input  logic                                 M_AXIS_tready
);

  localparam int HALF = AXIS_TDATA_WIDTH / 2;
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_WIDTH-1:0]   ERR_ONE   = {{(ERR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_WIDTH-1:0]   ERR_MAX   = '1;

  logic                   accept;
  logic                   bit_a_next, bit_a_q;
  logic                   bit_b_next, bit_b_q;
  delta_e                 delta;
  logic [COUNT_WIDTH-1:0] position_d, position_q;
  logic [COUNT_WIDTH-1:0] tdata_d, tdata_q;
  logic [ERR_WIDTH-1:0]   err_d, err_q;
  logic                   tvalid_d, tvalid_q;

  assign S_AXIS_tready = aresetn & (~tvalid_q | M_AXIS_tready);
  assign accept        = S_AXIS_tvalid & S_AXIS_tready;

  hysteresis_comparator #(.WIDTH(HALF)) u_hyst_a (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .sample   (S_AXIS_tdata[HALF-1:0]),
    .lower    (lower_threshold),
    .upper    (upper_threshold),
    .enable   (accept),
    .bit_next (bit_a_next),
    .bit_q    (bit_a_q)
  );

  hysteresis_comparator #(.WIDTH(HALF)) u_hyst_b (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .sample   (S_AXIS_tdata[2*HALF-1:HALF]),
    .lower    (lower_threshold),
    .upper    (upper_threshold),
    .enable   (accept),
    .bit_next (bit_b_next),
    .bit_q    (bit_b_q)
  );

  // The registered bits only move on an accept, so they are the previous accepted state.
  assign delta = quad_delta({bit_a_q, bit_b_q}, {bit_a_next, bit_b_next});

  always_comb begin
    position_d = position_q;
    err_d      = err_q;
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;

    if (clear) begin
      position_d = '0;
      err_d      = '0;
    end else if (accept) begin
      case (delta)
        DELTA_INC:     position_d = position_q + COUNT_ONE;
        DELTA_DEC:     position_d = position_q - COUNT_ONE;
        DELTA_ILLEGAL: if (err_q != ERR_MAX) err_d = err_q + ERR_ONE;
        default:       position_d = position_q;
      endcase
    end

    if (accept) begin
      tvalid_d = 1'b1;
      tdata_d  = position_d;
    end else if (M_AXIS_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      position_q <= '0;
      err_q      <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
    end else begin
      position_q <= position_d;
      err_q      <= err_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
    end
  end

  assign M_AXIS_tvalid = tvalid_q;
  assign M_AXIS_tdata  = tdata_q;
  assign error_count   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_fringe_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axis_fringe_counter: scoreboard bench, 8-bit counter configuration |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_axis_fringe_counter;

  localparam int DW = 32;
  localparam int HW = 16;
  localparam int CW = 8;
  localparam logic signed [HW-1:0] HI = 16'sd2000;
  localparam logic signed [HW-1:0] LO = -16'sd2000;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          clear = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] s_tdata = '0;
  logic          m_tvalid;
  logic [CW-1:0] m_tdata;
  logic          m_tready = 1'b0;
  logic [15:0]   err_cnt;
  logic signed [HW-1:0] lower_th = -16'sd1000;
  logic signed [HW-1:0] upper_th = 16'sd1000;

  int n_checks = 0;
  int n_errors = 0;

  logic [CW-1:0] sb_q[$];
  logic [CW-1:0] exp_pos;
  logic [CW-1:0] held;

  // Reference model state
  logic          m_a = 1'b0;
  logic          m_b = 1'b0;
  logic [CW-1:0] m_pos = '0;
  logic [15:0]   m_err = '0;

  // Quadrature states indexed 0..3 in forward order: 00, 01, 11, 10
  logic signed [HW-1:0] st_a [4] = '{LO, LO, HI, HI};
  logic signed [HW-1:0] st_b [4] = '{LO, HI, HI, LO};
  logic signed [HW-1:0] hy_a [6] = '{16'sd2000, 16'sd500, -16'sd500, -16'sd1500, 16'sd1000, 16'sd1001};
  logic                 hy_bit [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  always #5 aclk = ~aclk;

  axis_fringe_counter #(
    .AXIS_TDATA_WIDTH (DW),
    .COUNT_WIDTH      (CW)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .lower_threshold (lower_th),
    .upper_threshold (upper_th),
    .clear           (clear),
    .error_count     (err_cnt),
    .S_AXIS_tvalid   (s_tvalid),
    .S_AXIS_tdata    (s_tdata),
    .S_AXIS_tready   (s_tready),
    .M_AXIS_tvalid   (m_tvalid),
    .M_AXIS_tdata    (m_tdata),
    .M_AXIS_tready   (m_tready)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int qidx(input logic [1:0] q);
    case (q)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Drive one sample, wait for its accept, update the model and queue the expected word.
  task automatic send(input logic signed [HW-1:0] a, input logic signed [HW-1:0] b, input logic clr);
    logic got;
    logic na, nb;
    int   d;
    got      = 1'b0;
    s_tdata  = {b, a};
    s_tvalid = 1'b1;
    clear    = clr;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge aclk);
      got = s_tready;
    end
    if (!got) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      s_tvalid = 1'b0;
      clear    = 1'b0;
      return;
    end
    na = (a > upper_th) ? 1'b1 : ((a < lower_th) ? 1'b0 : m_a);
    nb = (b > upper_th) ? 1'b1 : ((b < lower_th) ? 1'b0 : m_b);
    d  = (qidx({na, nb}) - qidx({m_a, m_b}) + 4) % 4;
    if (clr) begin
      m_pos = '0;
      m_err = '0;
    end else if (d == 1) begin
      m_pos = m_pos + CW'(1);
    end else if (d == 3) begin
      m_pos = m_pos - CW'(1);
    end else if (d == 2 && m_err != 16'hFFFF) begin
      m_err = m_err + 16'd1;
    end
    m_a = na;
    m_b = nb;
    sb_q.push_back(m_pos);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    clear    = 1'b0;
  endtask

  always @(negedge aclk) begin
    if (aresetn && m_tvalid && m_tready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_pos = sb_q.pop_front();
        check_eq("position", 32'(m_tdata), 32'(exp_pos));
      end
    end
  end

  initial begin
    // Reset with a valid sample waiting
    s_tvalid = 1'b1;
    s_tdata  = {HI, HI};
    repeat (3) begin
      @(negedge aclk);
      check_eq("rst_s_tready", 32'(s_tready), 32'd0);
      check_eq("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      check_eq("rst_m_tdata", 32'(m_tdata), 32'd0);
      check_eq("rst_err", 32'(err_cnt), 32'd0);
    end
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    aresetn  = 1'b1;
    m_tready = 1'b1;

    // Forward then reverse through the quadrature cycle
    for (int i = 0; i < 5; i++) send(st_a[i % 4], st_b[i % 4], 1'b0);
    for (int i = 3; i >= 0; i--) send(st_a[i], st_b[i], 1'b0);

    // Hysteresis on channel a with b held low
    for (int i = 0; i < 6; i++) begin
      send(hy_a[i], LO, 1'b0);
      check_eq("hyst_bit_a", 32'(dut.u_hyst_a.bit_q), 32'(hy_bit[i]));
    end

    // Illegal transition 00 -> 11
    send(LO, LO, 1'b0);
    send(HI, HI, 1'b0);
    check_eq("illegal_err", 32'(err_cnt), 32'd1);

    // Drive the error counter into saturation
    for (int i = 0; i < 65535; i++) begin
      if (i % 2 == 0) send(LO, LO, 1'b0);
      else            send(HI, HI, 1'b0);
    end
    check_eq("err_saturated", 32'(err_cnt), 32'h0000FFFF);
    check_eq("err_model", 32'(err_cnt), 32'(m_err));

    // Clear coincident with a forward step 00 -> 01
    send(LO, HI, 1'b1);
    check_eq("clear_tdata", 32'(m_tdata), 32'd0);
    check_eq("clear_err", 32'(err_cnt), 32'd0);

    // Reverse step 01 -> 00 wraps the 8-bit counter
    send(LO, LO, 1'b0);
    check_eq("wrap_tdata", 32'(m_tdata), 32'h000000FF);

    // Backpressure: downstream stalls while 10 samples stream in
    fork
      begin
        for (int k = 1; k <= 10; k++) send(st_a[k % 4], st_b[k % 4], 1'b0);
      end
      begin
        repeat (3) @(posedge aclk);
        #1;
        m_tready = 1'b0;
        @(negedge aclk);
        held = m_tdata;
        check_eq("stall_s_tready", 32'(s_tready), 32'd0);
        repeat (4) begin
          @(negedge aclk);
          check_eq("stall_s_tready", 32'(s_tready), 32'd0);
          check_eq("stall_hold", 32'(m_tdata), 32'(held));
        end
        @(posedge aclk);
        #1;
        m_tready = 1'b1;
      end
    join

    repeat (5) @(negedge aclk);
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    check_eq("idle_m_tvalid", 32'(m_tvalid), 32'd0);
    check_eq("final_err", 32'(err_cnt), 32'(m_err));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
